// File: rtl/shoot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shoot_sequencer
// Purpose  : One-shot launcher trigger servo sequencer: fire frames, dwell,
//            rest frames.
// Revision : 1.0
// ============================================================================
module shoot_sequencer #(
    parameter int PERIOD_CYC   = 1000000,
    parameter int FIRE_WIDTH   = 90000,
    parameter int REST_WIDTH   = 50000,
    parameter int FIRE_FRAMES  = 100,
    parameter int REST_FRAMES  = 100,
    parameter int HOLD_CYC     = 100000000,
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       button,
    input  logic       abort,
    output logic       servo_pwm,
    output logic       busy,
    output logic       done,
    output logic [1:0] state_o
);

    localparam int PW   = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam int MAXF = (FIRE_FRAMES > REST_FRAMES) ? FIRE_FRAMES : REST_FRAMES;
    localparam int FW   = (MAXF > 1) ? $clog2(MAXF) : 1;
    localparam int HW   = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam int DW   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    localparam logic [PW-1:0] PCNT_LAST  = PW'(PERIOD_CYC - 1);
    localparam logic [PW-1:0] FIRE_W     = PW'(FIRE_WIDTH);
    localparam logic [PW-1:0] REST_W     = PW'(REST_WIDTH);
    localparam logic [FW-1:0] FIRE_LAST  = FW'(FIRE_FRAMES - 1);
    localparam logic [FW-1:0] REST_LAST  = FW'(REST_FRAMES - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYC - 1);
    localparam logic [DW-1:0] DCNT_LAST  = DW'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FIRE   = 2'd1,
        S_HOLD   = 2'd2,
        S_RETURN = 2'd3
    } state_t;

    state_t        state_q;
    logic [PW-1:0] pcnt_q;
    logic [FW-1:0] fcnt_q;
    logic [HW-1:0] hcnt_q;
    logic          pwm_q;
    logic          done_q;

    logic          sync1_q;
    logic          sync2_q;
    logic [DW-1:0] dcnt_q;
    logic [DW-1:0] dcnt_d;
    logic          armed_q;
    logic          armed_d;
    logic          press_evt;

    // Counter saturates at the threshold; armed guarantees one event per press.
    always_comb begin
        dcnt_d    = dcnt_q;
        armed_d   = armed_q;
        press_evt = 1'b0;
        if (sync2_q) begin
            dcnt_d  = '0;
            armed_d = 1'b1;
        end else if (dcnt_q == DCNT_LAST) begin
            press_evt = armed_q;
            armed_d   = 1'b0;
        end else begin
            dcnt_d = dcnt_q + DW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            dcnt_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= button;
            sync2_q <= sync1_q;
            dcnt_q  <= dcnt_d;
            armed_q <= armed_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            pcnt_q  <= '0;
            fcnt_q  <= '0;
            hcnt_q  <= '0;
            pwm_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            pwm_q  <= ((state_q == S_FIRE)   && (pcnt_q < FIRE_W)) ||
                      ((state_q == S_RETURN) && (pcnt_q < REST_W));
            case (state_q)
                S_IDLE: begin
                    if (press_evt) begin
                        state_q <= S_FIRE;
                        pcnt_q  <= '0;
                        fcnt_q  <= '0;
                    end
                end
                S_FIRE: begin
                    if (abort) begin
                        // Cut any fire pulse short so it never merges into the rest pulse.
                        state_q <= S_RETURN;
                        pcnt_q  <= '0;
                        fcnt_q  <= '0;
                        pwm_q   <= 1'b0;
                    end else if (pcnt_q == PCNT_LAST) begin
                        pcnt_q <= '0;
                        fcnt_q <= fcnt_q + FW'(1);
                        if (fcnt_q == FIRE_LAST) begin
                            state_q <= S_HOLD;
                            hcnt_q  <= '0;
                        end
                    end else begin
                        pcnt_q <= pcnt_q + PW'(1);
                    end
                end
                S_HOLD: begin
                    if (abort || (hcnt_q == HOLD_LAST)) begin
                        state_q <= S_RETURN;
                        pcnt_q  <= '0;
                        fcnt_q  <= '0;
                    end else begin
                        hcnt_q <= hcnt_q + HW'(1);
                    end
                end
                S_RETURN: begin
                    if (pcnt_q == PCNT_LAST) begin
                        pcnt_q <= '0;
                        fcnt_q <= fcnt_q + FW'(1);
                        if (fcnt_q == REST_LAST) begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        pcnt_q <= pcnt_q + PW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign servo_pwm = pwm_q;
    assign done      = done_q;
    assign busy      = (state_q != S_IDLE);
    assign state_o   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_shoot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_shoot_sequencer
// Purpose  : Vector table, directed corner sequences and random stimulus
//            against a timeline model of the shot sequence.
// Revision : 1.0
// ============================================================================
module tb_shoot_sequencer;

    localparam int P  = 100;
    localparam int WF = 18;
    localparam int WR = 10;
    localparam int NF = 3;
    localparam int NR = 2;
    localparam int HC = 50;
    localparam int DB = 4;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       button = 1'b1;
    logic       abort = 1'b0;
    logic       servo_pwm;
    logic       busy;
    logic       done;
    logic [1:0] state_o;

    shoot_sequencer #(
        .PERIOD_CYC  (P),
        .FIRE_WIDTH  (WF),
        .REST_WIDTH  (WR),
        .FIRE_FRAMES (NF),
        .REST_FRAMES (NR),
        .HOLD_CYC    (HC),
        .DEBOUNCE_CYC(DB)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .button   (button),
        .abort    (abort),
        .servo_pwm(servo_pwm),
        .busy     (busy),
        .done     (done),
        .state_o  (state_o)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cyc_n = 0;

    // Timeline model: m_t counts cycles since the shot started, m_r marks an
    // aborted jump into the rest phase.
    int m_t = -1;
    int m_r = -1;
    bit m_pwm = 0;
    bit m_done = 0;
    bit m_s1 = 1;
    bit m_s2 = 1;
    int m_run = 0;
    bit m_armed = 0;

    int run_len = 0;
    int done_cnt = 0;
    int widths[$];
    int exp_w[$];

    function automatic int m_phase();
        if (m_t < 0) return 0;
        if (m_r >= 0) return 3;
        if (m_t < NF * P) return 1;
        if (m_t < NF * P + HC) return 2;
        return 3;
    endfunction

    function automatic int m_rt();
        return (m_r >= 0) ? (m_t - m_r) : (m_t - (NF * P + HC));
    endfunction

    task automatic model_edge(input logic rn, input logic b, input logic a);
        int  ph;
        bit  press;
        if (!rn) begin
            m_t = -1; m_r = -1; m_pwm = 0; m_done = 0;
            m_s1 = 1; m_s2 = 1; m_run = 0; m_armed = 0;
            return;
        end
        ph     = m_phase();
        press  = !m_s2 && (m_run == DB) && m_armed;
        m_pwm  = (ph == 1 && (m_t % P) < WF) || (ph == 3 && (m_rt() % P) < WR);
        m_done = 0;
        case (ph)
            0: if (press) begin m_t = 0; m_r = -1; end
            1, 2: begin
                if (a) begin m_pwm = 0; m_t++; m_r = m_t; end
                else m_t++;
            end
            default: begin
                if (m_rt() == NR * P - 1) begin m_t = -1; m_r = -1; m_done = 1; end
                else m_t++;
            end
        endcase
        if (press) m_armed = 0;
        m_s2 = m_s1;
        m_s1 = b;
        if (m_s2) begin m_run = 0; m_armed = 1; end
        else m_run++;
    endtask

    task automatic cyc();
        @(posedge clock);
        model_edge(resetn, button, abort);
        @(negedge clock);
        cyc_n++;
        checks++;
        if (state_o !== 2'(m_phase()) || busy !== (m_t >= 0) ||
            servo_pwm !== m_pwm || done !== m_done) begin
            failures++;
            $display("FAIL model cyc=%0d state=%0d exp=%0d busy=%b exp=%b pwm=%b exp=%b done=%b exp=%b",
                     cyc_n, state_o, m_phase(), busy, (m_t >= 0), servo_pwm, m_pwm, done, m_done);
        end
        if (servo_pwm === 1'b1) run_len++;
        else if (run_len > 0) begin widths.push_back(run_len); run_len = 0; end
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic clear_mon();
        widths.delete();
        run_len  = 0;
        done_cnt = 0;
    endtask

    task automatic check_pulses(input string nm, input int exp_done);
        check({nm, ".npulses"}, widths.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < widths.size(); i++)
            check($sformatf("%s.width%0d", nm, i), widths[i], exp_w[i]);
        check({nm, ".done_cnt"}, done_cnt, exp_done);
    endtask

    task automatic wait_fire(input int maxc, output int n);
        n = 0;
        while (n < maxc && state_o !== 2'd1) begin
            cyc();
            n++;
        end
    endtask

    typedef struct {
        logic rn;
        logic btn;
        int   n;
        int   st;
        logic pwm;
        logic dn;
    } vec_t;

    vec_t vt[$];

    initial begin
        #500000;
        $display("FAIL watchdog expired at cyc=%0d", cyc_n);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Basic sequence from reset, then bounce rejection.
        vt.push_back('{1'b0, 1'b1,   2, 0, 1'b0, 1'b0});
        vt.push_back('{1'b1, 1'b1,   3, 0, 1'b0, 1'b0});
        vt.push_back('{1'b1, 1'b0,   5, 0, 1'b0, 1'b0});
        vt.push_back('{1'b1, 1'b0,   1, 1, 1'b0, 1'b0});
        vt.push_back('{1'b1, 1'b0,   1, 1, 1'b1, 1'b0});
        vt.push_back('{1'b1, 1'b0,  17, 1, 1'b1, 1'b0});
        vt.push_back('{1'b1, 1'b0,   1, 1, 1'b0, 1'b0});
        vt.push_back('{1'b1, 1'b0,  82, 1, 1'b1, 1'b0});
        vt.push_back('{1'b1, 1'b0, 198, 1, 1'b0, 1'b0});
        vt.push_back('{1'b1, 1'b0,   1, 2, 1'b0, 1'b0});
        vt.push_back('{1'b1, 1'b0,  50, 3, 1'b0, 1'b0});
        vt.push_back('{1'b1, 1'b0,   1, 3, 1'b1, 1'b0});
        vt.push_back('{1'b1, 1'b0,   9, 3, 1'b1, 1'b0});
        vt.push_back('{1'b1, 1'b0,   1, 3, 1'b0, 1'b0});
        vt.push_back('{1'b1, 1'b0, 188, 3, 1'b0, 1'b0});
        vt.push_back('{1'b1, 1'b0,   1, 0, 1'b0, 1'b1});
        vt.push_back('{1'b1, 1'b0,   1, 0, 1'b0, 1'b0});
        vt.push_back('{1'b1, 1'b1,   4, 0, 1'b0, 1'b0});
        for (int k = 0; k < 5; k++) begin
            vt.push_back('{1'b1, 1'b0, 3, 0, 1'b0, 1'b0});
            vt.push_back('{1'b1, 1'b1, 1, 0, 1'b0, 1'b0});
        end
        vt.push_back('{1'b1, 1'b1, 10, 0, 1'b0, 1'b0});

        clear_mon();
        foreach (vt[i]) begin
            resetn = vt[i].rn;
            button = vt[i].btn;
            repeat (vt[i].n) cyc();
            check($sformatf("vec%0d.state", i), int'(state_o), vt[i].st);
            check($sformatf("vec%0d.busy", i), int'(busy), int'(vt[i].st != 0));
            check($sformatf("vec%0d.pwm", i), int'(servo_pwm), int'(vt[i].pwm));
            check($sformatf("vec%0d.done", i), int'(done), int'(vt[i].dn));
            if (i == 16) begin
                exp_w = '{18, 18, 18, 10, 10};
                check_pulses("basic", 1);
            end
        end

        // Held button: one sequence only, then release/re-press restarts.
        clear_mon();
        button = 1'b0;
        wait_fire(20, n);
        check("held.latency", n, 6);
        repeat (560) cyc();
        check("held.idle_after", int'(state_o), 0);
        exp_w = '{18, 18, 18, 10, 10};
        check_pulses("held", 1);
        button = 1'b1;
        cyc();
        button = 1'b0;
        clear_mon();
        wait_fire(20, n);
        check("repress.latency", n, 6);

        // Press during HOLD is dropped.
        button = 1'b1;
        repeat (300) cyc();
        check("busy_press.in_hold", int'(state_o), 2);
        button = 1'b0;
        repeat (10) cyc();
        check("busy_press.still_hold", int'(state_o), 2);
        repeat (290) cyc();
        check("busy_press.idle", int'(state_o), 0);
        check_pulses("busy_press", 1);

        // Abort at pcnt=5 of fire frame 1.
        button = 1'b1;
        repeat (3) cyc();
        button = 1'b0;
        clear_mon();
        wait_fire(20, n);
        check("abort.latency", n, 6);
        repeat (105) cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check("abort.return", int'(state_o), 3);
        button = 1'b1;
        repeat (210) cyc();
        check("abort.idle", int'(state_o), 0);
        exp_w = '{18, 5, 10, 10};
        check_pulses("abort", 1);

        // Reset during RETURN frame 0, pcnt=3.
        button = 1'b0;
        clear_mon();
        wait_fire(20, n);
        check("rst.latency", n, 6);
        repeat (353) cyc();
        check("rst.in_return", int'(state_o), 3);
        button = 1'b1;
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
        check("rst.pwm", int'(servo_pwm), 0);
        check("rst.busy", int'(busy), 0);
        check("rst.state", int'(state_o), 0);
        done_cnt = 0;
        repeat (30) cyc();
        check("rst.no_done", done_cnt, 0);
        button = 1'b0;
        clear_mon();
        wait_fire(20, n);
        check("rst.new_latency", n, 6);
        repeat (560) cyc();
        exp_w = '{18, 18, 18, 10, 10};
        check_pulses("rst.new_seq", 1);

        // Random stimulus against the model.
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(7) == 0) button = ~button;
            abort  = ($urandom_range(149) == 0);
            resetn = ($urandom_range(2999) != 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shoot_sequencer.md
Name: shoot_sequencer

Overview:
Synthesizable controller that sequences the launcher trigger servo for one shot. A debounced button press starts the sequence: FIRE_FRAMES servo frames at the fire pulse width, a HOLD_CYC dwell with the PWM line low, then REST_FRAMES frames at the rest pulse width. It sits between the front-panel button and the servo pin. It generates the 20 ms frame timing itself. A press while the sequence runs is dropped.

Parameters:
PERIOD_CYC, 1000000, servo frame length in clocks (20 ms at 50 MHz)
FIRE_WIDTH, 90000, fire-position high time in clocks (1.8 ms); must be < PERIOD_CYC
REST_WIDTH, 50000, rest-position high time in clocks (1.0 ms); must be < PERIOD_CYC
FIRE_FRAMES, 100, number of fire frames; ≥1
REST_FRAMES, 100, number of rest frames; ≥1
HOLD_CYC, 100000000, dwell between phases in clocks (2 s); ≥1
DEBOUNCE_CYC, 1000000, clocks the synchronized button must stay stably low to register a press; ≥1

Ports:
clock  input  1  system clock, 50 MHz
resetn  input  1  synchronous active-low reset
button  input  1  raw push button, active low, asynchronous to clock
abort  input  1  synchronous; ends the fire/hold phase early
servo_pwm  output  1  servo control line, registered
busy  output  1  high when state != IDLE
done  output  1  one-cycle pulse when the sequence completes
state_o  output  2  current state: 0 IDLE, 1 FIRE, 2 HOLD, 3 RETURN

Behaviour:
- Reset: resetn sampled low at a rising edge forces the following, including mid-sequence.
  - state IDLE; servo_pwm=0; busy=0; done=0.
  - All counters cleared; synchronizer flops set to 1 (released).
  - Debounce "armed" flag cleared.
- Button input path:
  - 2-flop synchronizer; the debounce counter follows it.
  - The counter increments while the synchronized button is 0 and clears to 0 when it is 1.
  - press_evt is a one-cycle pulse in the cycle the counter reaches DEBOUNCE_CYC-1 with the button still low.
  - The counter then saturates. No further press is possible until the button reads 1 for at least one cycle (release re-arms).
- Counters:
  - pcnt: frame position, 0..PERIOD_CYC-1.
  - fcnt: frame index.
  - hcnt: hold counter.
- IDLE:
  - servo_pwm=0.
  - press_evt → FIRE next cycle, with pcnt=0 and fcnt=0.
- FIRE:
  - pcnt increments every cycle.
  - At pcnt==PERIOD_CYC-1, pcnt wraps to 0 and fcnt increments.
  - At the wrap with fcnt==FIRE_FRAMES-1 → HOLD, hcnt=0.
- HOLD:
  - hcnt increments.
  - At hcnt==HOLD_CYC-1 → RETURN, with pcnt=0 and fcnt=0.
- RETURN:
  - Same framing as FIRE.
  - At the wrap with fcnt==REST_FRAMES-1 → IDLE; done=1 in that same cycle.
- PWM generation:
  - servo_pwm is registered from the current state and pcnt: (FIRE && pcnt<FIRE_WIDTH) || (RETURN && pcnt<REST_WIDTH).
  - It is therefore 1 cycle late relative to state/pcnt; each high pulse is exactly the programmed width.
  - servo_pwm is 0 in IDLE and HOLD.
- abort:
  - In FIRE or HOLD, abort → RETURN next cycle, with pcnt=0 and fcnt=0. Any partial high pulse is truncated.
  - abort is ignored in IDLE and RETURN.
  - abort and press_evt in the same cycle while IDLE: the press wins (abort ignored in IDLE).
- press_evt in any state other than IDLE is discarded, not queued.
- done and press_evt in the same cycle: IDLE is entered; the press is discarded. A new sequence requires release and a re-press.
- busy is driven directly from the state register: 1 in FIRE, HOLD and RETURN.

Test Plan:
All scenarios use bench parameters PERIOD_CYC=100, FIRE_WIDTH=18, REST_WIDTH=10, FIRE_FRAMES=3, REST_FRAMES=2, HOLD_CYC=50, DEBOUNCE_CYC=4.
1. Basic sequence:
   - Stimulus: hold button low ≥10 cycles.
   - Response: exactly 3 pwm pulses, each 18 cycles high, rising edges 100 cycles apart. Then 50+82 low cycles (hold plus the remaining tail). Then 2 pulses of 10 cycles.
   - done pulses once, 550 cycles after FIRE is entered. busy=1 for all 550 of those cycles.
2. Bounce rejection:
   - Stimulus: button toggles low 3 cycles / high 1 cycle ×5, then returns high.
   - Response: no press_evt; state stays IDLE; servo_pwm=0.
3. Held button / re-press:
   - Stimulus: button held low through the entire sequence, then released 1 cycle, then low again.
   - Response: one sequence only while held; a second sequence starts 4+2 cycles after the re-press.
4. Press while busy:
   - Stimulus: second debounced press during HOLD.
   - Response: ignored. Pulse counts stay 3/2 and done fires once.
5. Abort:
   - Stimulus: abort asserted at pcnt=5 of fire frame 1.
   - Response: the 18-cycle pulse is truncated to 5 cycles. RETURN starts the next cycle and issues 2 × 10-cycle pulses, then done.
6. Reset mid-sequence:
   - Stimulus: resetn=0 for 1 cycle during RETURN frame 0 at pcnt=3.
   - Response: servo_pwm=0 and busy=0 the following cycle. No done pulse. A new press starts a full sequence.
